stack_machine_ext: RTL and testbench

//   Parametrised RPN stack calculator: N-bit data, S-entry stack, 8-op ISA.

---
 rtl/stack_machine_ext.sv | 171 +++++++++++++++++
 tb/tb_stack_machine_ext.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_machine_ext.sv
// stack_machine_ext: RPN stack calculator with an N-bit datapath and S-entry stack.
// Executes one opcode per clock. The top of stack is held in a register and driven on o.
// Illegal ops leave the machine unchanged and set sticky ovf/unf flags.
module stack_machine_ext #(
  parameter int N = 8,
  parameter int S = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [N-1:0]             x,
  input  logic [2:0]               opcode,
  output logic [N-1:0]             o,
  output logic [$clog2(S+1)-1:0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int DW = $clog2(S+1);
  localparam int AW = $clog2(S);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_PUSH = 3'd4,
    OP_POP  = 3'd5,
    OP_DUP  = 3'd6,
    OP_SWAP = 3'd7
  } op_t;

  op_t            op;
  logic [N-1:0]   stk [S];

  logic [AW-1:0]  idx_t, idx_u, idx_p;
  logic [N-1:0]   t, u, arith;
  logic           has1, has2;

  logic           wa_en, wb_en;
  logic [AW-1:0]  wa_idx, wb_idx;
  logic [N-1:0]   wa_data, wb_data;
  logic [DW-1:0]  depth_nxt;
  logic [N-1:0]   o_nxt;
  logic           set_ovf, set_unf;

  assign op    = op_t'(opcode);
  assign empty = (depth == '0);
  assign full  = (depth == DW'(S));
  assign has1  = !empty;
  assign has2  = (depth >= DW'(2));

  // Slot addresses for T, U and the next free entry; only used when the op is legal.
  assign idx_t = AW'(depth - DW'(1));
  assign idx_u = AW'(depth - DW'(2));
  assign idx_p = AW'(depth);
  assign t     = stk[idx_t];
  assign u     = stk[idx_u];

  // Binary arithmetic result U op T, modulo 2^N.
  always_comb begin
    arith = '0;
    case (op)
      OP_ADD:  arith = u + t;
      OP_SUB:  arith = u - t;
      OP_MUL:  arith = u * t;
      default: arith = '0;
    endcase
  end

  // Decode: legality guards, storage writes, next depth and next top-of-stack.
  always_comb begin
    wa_en     = 1'b0;
    wa_idx    = '0;
    wa_data   = '0;
    wb_en     = 1'b0;
    wb_idx    = '0;
    wb_data   = '0;
    depth_nxt = depth;
    o_nxt     = o;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL: begin
        if (has2) begin
          wa_en     = 1'b1;
          wa_idx    = idx_u;
          wa_data   = arith;
          depth_nxt = depth - DW'(1);
          o_nxt     = arith;
        end else begin
          set_unf = 1'b1;
        end
      end
      OP_PUSH: begin
        if (!full) begin
          wa_en     = 1'b1;
          wa_idx    = idx_p;
          wa_data   = x;
          depth_nxt = depth + DW'(1);
          o_nxt     = x;
        end else begin
          set_ovf = 1'b1;
        end
      end
      OP_POP: begin
        if (has1) begin
          depth_nxt = depth - DW'(1);
          // U becomes the new top; an emptied stack shows 0.
          o_nxt     = has2 ? u : '0;
        end else begin
          set_unf = 1'b1;
        end
      end
      OP_DUP: begin
        if (!has1) begin
          set_unf = 1'b1;
        end else if (full) begin
          set_ovf = 1'b1;
        end else begin
          wa_en     = 1'b1;
          wa_idx    = idx_p;
          wa_data   = t;
          depth_nxt = depth + DW'(1);
          o_nxt     = t;
        end
      end
      OP_SWAP: begin
        if (has2) begin
          wa_en   = 1'b1;
          wa_idx  = idx_t;
          wa_data = u;
          wb_en   = 1'b1;
          wb_idx  = idx_u;
          wb_data = t;
          o_nxt   = u;
        end else begin
          set_unf = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State update: async reset, then synchronous clear, then the decoded op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < S; i++) stk[i] <= '0;
      depth <= '0;
      o     <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (clr) begin
      for (int unsigned i = 0; i < S; i++) stk[i] <= '0;
      depth <= '0;
      o     <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (wa_en) stk[wa_idx] <= wa_data;
      if (wb_en) stk[wb_idx] <= wb_data;
      depth <= depth_nxt;
      o     <= o_nxt;
      if (set_ovf) ovf <= 1'b1;
      if (set_unf) unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stack_machine_ext.sv
// Scoreboard bench for stack_machine_ext: the driver queues hand-computed expected
// states, and a monitor pops and compares them on the falling edge.
module tb_stack_machine_ext;

  localparam int N = 8;
  localparam int S = 8;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] ADD  = 3'd1;
  localparam logic [2:0] SUB  = 3'd2;
  localparam logic [2:0] MUL  = 3'd3;
  localparam logic [2:0] PUSH = 3'd4;
  localparam logic [2:0] POP  = 3'd5;
  localparam logic [2:0] DUP  = 3'd6;
  localparam logic [2:0] SWAP = 3'd7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] x = '0;
  logic [2:0]   opcode = NOP;
  logic [N-1:0] o;
  logic [3:0]   depth;
  logic         empty, full, ovf, unf;

  typedef struct {
    string      name;
    logic [7:0] o;
    logic [3:0] depth;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_ev;

  stack_machine_ext #(.N(N), .S(S)) dut (
    .clk(clk), .rst(rst), .clr(clr), .x(x), .opcode(opcode),
    .o(o), .depth(depth), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic expect_st(input string nm, input logic [7:0] eo, input int ed,
                           input logic eov, input logic eun);
    exp_t e;
    e.name  = nm;
    e.o     = eo;
    e.depth = 4'(ed);
    e.empty = (ed == 0);
    e.full  = (ed == S);
    e.ovf   = eov;
    e.unf   = eun;
    q.push_back(e);
  endtask

  task automatic do_op(input logic [2:0] opc, input logic [7:0] xv);
    @(negedge clk);
    opcode = opc;
    x      = xv;
    @(posedge clk);
    #1;
    opcode = NOP;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr    = 1'b1;
    opcode = PUSH;
    x      = 8'h55;
    @(posedge clk);
    #1;
    clr    = 1'b0;
    opcode = NOP;
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() != 0) begin
        e = q.pop_front();
        n_cmp++;
        if (o !== e.o || depth !== e.depth || empty !== e.empty || full !== e.full ||
            ovf !== e.ovf || unf !== e.unf) begin
          n_bad++;
          $display("FAIL %s: got o=%h depth=%0d empty=%b full=%b ovf=%b unf=%b, want o=%h depth=%0d empty=%b full=%b ovf=%b unf=%b",
                   e.name, o, depth, empty, full, ovf, unf,
                   e.o, e.depth, e.empty, e.full, e.ovf, e.unf);
        end
      end
    end
  end

  // Driver: directed sequences with hand-computed results.
  initial begin
    int waited;
    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1 expect_st("reset", 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // 1: 2 4 5 * 6 + + -> 28
    do_op(PUSH, 8'd2);
    do_op(PUSH, 8'd4);
    do_op(PUSH, 8'd5);
    expect_st("push3", 8'd5, 3, 1'b0, 1'b0);
    do_op(MUL, 8'd0);
    expect_st("mul45", 8'd20, 2, 1'b0, 1'b0);
    do_op(PUSH, 8'd6);
    do_op(ADD, 8'd0);
    expect_st("add26", 8'd26, 2, 1'b0, 1'b0);
    do_op(ADD, 8'd0);
    expect_st("t1_final", 8'd28, 1, 1'b0, 1'b0);
    do_op(NOP, 8'hEE);
    expect_st("nop_hold", 8'd28, 1, 1'b0, 1'b0);
    do_clr();
    expect_st("clr_over_push", 8'h00, 0, 1'b0, 1'b0);

    // 2: 9 3 SWAP SUB -> 3-9 = 0xFA
    do_op(PUSH, 8'd9);
    do_op(PUSH, 8'd3);
    do_op(SWAP, 8'd0);
    expect_st("swap", 8'd9, 2, 1'b0, 1'b0);
    do_op(SUB, 8'd0);
    expect_st("sub_wrap", 8'hFA, 1, 1'b0, 1'b0);
    do_clr();

    // 3: 20 DUP MUL -> 0x90; DUP POP POP -> empty
    do_op(PUSH, 8'd20);
    do_op(DUP, 8'd0);
    expect_st("dup", 8'd20, 2, 1'b0, 1'b0);
    do_op(MUL, 8'd0);
    expect_st("mul_wrap", 8'h90, 1, 1'b0, 1'b0);
    do_op(DUP, 8'd0);
    do_op(POP, 8'd0);
    expect_st("pop_to1", 8'h90, 1, 1'b0, 1'b0);
    do_op(POP, 8'd0);
    expect_st("pop_empty", 8'h00, 0, 1'b0, 1'b0);
    do_clr();

    // 4: fill, overflow, binary op at full, push again
    for (int i = 1; i <= S; i++) do_op(PUSH, 8'(i));
    expect_st("full", 8'(S), S, 1'b0, 1'b0);
    do_op(PUSH, 8'hAA);
    expect_st("push_ovf", 8'(S), S, 1'b1, 1'b0);
    do_op(ADD, 8'd0);
    expect_st("add_at_full", 8'(2*S-1), S-1, 1'b1, 1'b0);
    do_op(PUSH, 8'h33);
    expect_st("push_after_free", 8'h33, S, 1'b1, 1'b0);
    do_clr();
    expect_st("clr_ovf", 8'h00, 0, 1'b0, 1'b0);
    for (int i = 1; i <= S; i++) do_op(PUSH, 8'(i + 16));
    do_op(DUP, 8'd0);
    expect_st("dup_ovf", 8'(S + 16), S, 1'b1, 1'b0);
    do_clr();

    // 5: underflow cases
    do_op(DUP, 8'd0);
    expect_st("dup_empty_unf", 8'h00, 0, 1'b0, 1'b1);
    do_clr();
    do_op(PUSH, 8'd7);
    do_op(ADD, 8'd0);
    expect_st("add_unf", 8'd7, 1, 1'b0, 1'b1);
    do_op(SWAP, 8'd0);
    expect_st("swap_unf", 8'd7, 1, 1'b0, 1'b1);
    do_op(POP, 8'd0);
    expect_st("pop_last", 8'h00, 0, 1'b0, 1'b1);
    do_op(POP, 8'd0);
    expect_st("pop_unf", 8'h00, 0, 1'b0, 1'b1);
    do_op(PUSH, 8'd11);
    expect_st("legal_after_unf", 8'd11, 1, 1'b0, 1'b1);
    do_clr();
    expect_st("clr_unf", 8'h00, 0, 1'b0, 1'b0);

    // 6: asynchronous reset while MUL is applied
    do_op(PUSH, 8'd1);
    do_op(PUSH, 8'd2);
    do_op(PUSH, 8'd3);
    expect_st("pre_rst", 8'd3, 3, 1'b0, 1'b0);
    @(negedge clk);
    opcode = MUL;
    #2 rst = 1'b0;
    #1 expect_st("async_rst", 8'h00, 0, 1'b0, 1'b0);
    ->chk_ev;
    @(negedge clk);
    opcode = NOP;
    rst    = 1'b1;
    do_op(PUSH, 8'd5);
    expect_st("push_after_rst", 8'd5, 1, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
